// File: rtl/hazard3_pmp_arb_pkg.sv
// Shared encodings for the Hazard3 PMP lookup arbiter: PMP access types,
// response source IDs and the arbiter grant enumeration.
package hazard3_pmp_arb_pkg;

  localparam logic [1:0] PMP_TYPE_R = 2'b00;
  localparam logic [1:0] PMP_TYPE_W = 2'b01;
  localparam logic [1:0] PMP_TYPE_X = 2'b10;

  localparam logic RSP_SRC_I = 1'b0;
  localparam logic RSP_SRC_D = 1'b1;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_I    = 2'b01,
    GRANT_D    = 2'b10
  } grant_t;

  // Instruction fetches always look up as execute; data side as read or write.
  function automatic logic [1:0] pmp_type_for(input logic is_d, input logic write);
    if (!is_d) begin
      return PMP_TYPE_X;
    end
    return write ? PMP_TYPE_W : PMP_TYPE_R;
  endfunction

endpackage

// File: rtl/hazard3_pmp_arb_prio.sv
// Grant selection for the PMP lookup arbiter: d-over-i priority with an
// i-side starvation counter that forces an i grant after STARVE_LIMIT losses.
module hazard3_pmp_arb_prio
  import hazard3_pmp_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   can_accept,
  input  logic   i_valid,
  input  logic   d_valid,
  output grant_t grant
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);

  always_comb begin
    grant = GRANT_NONE;
    if (can_accept) begin
      if (starved && i_valid) begin
        grant = GRANT_I;
      end else if (d_valid) begin
        grant = GRANT_D;
      end else if (i_valid) begin
        grant = GRANT_I;
      end
    end
  end

  // A loss only counts on cycles where a grant was actually handed out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!i_valid || grant == GRANT_I) begin
      starve_cnt <= '0;
    end else if (can_accept && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard3_pmp_arb.sv
// Shares one PMP lookup port between fetch and load/store through a 2-stage
// pipeline. Optional fault capture: define HAZARD3_PMP_ARB_FAULT_CAPTURE_EN.
module hazard3_pmp_arb
  import hazard3_pmp_arb_pkg::*;
#(
  parameter int W_ADDR       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [W_ADDR-1:0] i_req_addr,
  input  logic              i_req_m_mode,
  input  logic              i_req_32bit,

  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [W_ADDR-1:0] d_req_addr,
  input  logic              d_req_m_mode,
  input  logic              d_req_write,

  input  logic              cfg_wen,

  output logic [W_ADDR-1:0] pmp_addr,
  output logic              pmp_m_mode,
  output logic [1:0]        pmp_type,
  output logic              pmp_32bit,
  input  logic              pmp_kill,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_src,
  output logic              rsp_kill
`ifdef HAZARD3_PMP_ARB_FAULT_CAPTURE_EN
  ,
  input  logic              fault_clr,
  output logic              fault_sticky,
  output logic [W_ADDR-1:0] fault_addr,
  output logic              fault_src
`endif
);

  logic              s1_valid;
  logic [W_ADDR-1:0] s1_addr;
  logic              s1_m_mode;
  logic [1:0]        s1_type;
  logic              s1_32bit;
  logic              s1_src;

  logic              s2_valid;
  logic              s2_src;
  logic              s2_kill;

  logic              s2_load;
  logic              s1_accept;
  grant_t            grant;

  // A config write in flight blocks S1 so the lookup repeats against new config.
  assign s2_load   = s1_valid && !cfg_wen && (!s2_valid || rsp_ready);
  assign s1_accept = !s1_valid || s2_load;

  hazard3_pmp_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) prio (
    .clk       (clk),
    .rst_n     (rst_n),
    .can_accept(s1_accept),
    .i_valid   (i_req_valid),
    .d_valid   (d_req_valid),
    .grant     (grant)
  );

  assign i_req_ready = (grant == GRANT_I);
  assign d_req_ready = (grant == GRANT_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      s1_m_mode <= 1'b0;
      s1_type   <= PMP_TYPE_R;
      s1_32bit  <= 1'b0;
      s1_src    <= RSP_SRC_I;
    end else if (grant == GRANT_D) begin
      s1_valid  <= 1'b1;
      s1_addr   <= d_req_addr;
      s1_m_mode <= d_req_m_mode;
      s1_type   <= pmp_type_for(1'b1, d_req_write);
      s1_32bit  <= 1'b0;
      s1_src    <= RSP_SRC_D;
    end else if (grant == GRANT_I) begin
      s1_valid  <= 1'b1;
      s1_addr   <= i_req_addr;
      s1_m_mode <= i_req_m_mode;
      s1_type   <= pmp_type_for(1'b0, 1'b0);
      s1_32bit  <= i_req_32bit;
      s1_src    <= RSP_SRC_I;
    end else if (s2_load) begin
      s1_valid  <= 1'b0;
    end
  end

  assign pmp_addr   = s1_valid ? s1_addr : '0;
  assign pmp_m_mode = s1_valid & s1_m_mode;
  assign pmp_type   = s1_valid ? s1_type : 2'b00;
  assign pmp_32bit  = s1_valid & s1_32bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_src   <= RSP_SRC_I;
      s2_kill  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_src   <= s1_src;
      s2_kill  <= pmp_kill;
    end else if (rsp_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign rsp_valid = s2_valid;
  assign rsp_src   = s2_valid & s2_src;
  assign rsp_kill  = s2_valid & s2_kill;

`ifdef HAZARD3_PMP_ARB_FAULT_CAPTURE_EN
  // First denied lookup is kept until software acknowledges it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_sticky <= 1'b0;
      fault_addr   <= '0;
      fault_src    <= RSP_SRC_I;
    end else if (fault_clr) begin
      fault_sticky <= 1'b0;
    end else if (s2_load && pmp_kill && !fault_sticky) begin
      fault_sticky <= 1'b1;
      fault_addr   <= s1_addr;
      fault_src    <= s1_src;
    end
  end
`endif

endmodule

// File: tb/tb_hazard3_pmp_arb.sv
// Self-checking bench for hazard3_pmp_arb: directed scenarios plus random traffic
// checked against a transaction-queue reference model.
module tb_hazard3_pmp_arb;
  import hazard3_pmp_arb_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0, i_req_m_mode = 1'b0, i_req_32bit = 1'b0;
  logic [31:0] i_req_addr = '0;
  logic        d_req_valid = 1'b0, d_req_m_mode = 1'b0, d_req_write = 1'b0;
  logic [31:0] d_req_addr = '0;
  logic        cfg_wen = 1'b0, rsp_ready = 1'b0;
  logic        i_req_ready, d_req_ready;
  logic [31:0] pmp_addr;
  logic        pmp_m_mode, pmp_32bit, pmp_kill;
  logic [1:0]  pmp_type;
  logic        rsp_valid, rsp_src, rsp_kill;

  logic        z_i_ready, z_d_ready, z_pmp_m, z_pmp_32, z_rsp_valid, z_rsp_src, z_rsp_kill;
  logic [31:0] z_pmp_addr;
  logic [1:0]  z_pmp_type;

  logic [31:0] cfg_gen = '0;

`ifdef HAZARD3_PMP_ARB_FAULT_CAPTURE_EN
  logic        fault_clr = 1'b0;
  logic        fault_sticky, fault_src, z_fault_sticky, z_fault_src;
  logic [31:0] fault_addr, z_fault_addr;
  logic        m_sticky = 1'b0, m_fsrc = 1'b0;
  logic [31:0] m_faddr = '0;
`endif

  always #5 clk = ~clk;

  // Environment PMP: deterministic kill from address, access type and config generation.
  function automatic logic kill_fn(input logic [31:0] a, input logic [1:0] t, input logic [31:0] g);
    return (^a[7:0]) ^ t[0] ^ g[0];
  endfunction

  assign pmp_kill = kill_fn(pmp_addr, pmp_type, cfg_gen);

  hazard3_pmp_arb #(.W_ADDR(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_req_m_mode(i_req_m_mode), .i_req_32bit(i_req_32bit),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_m_mode(d_req_m_mode), .d_req_write(d_req_write),
    .cfg_wen(cfg_wen),
    .pmp_addr(pmp_addr), .pmp_m_mode(pmp_m_mode), .pmp_type(pmp_type),
    .pmp_32bit(pmp_32bit), .pmp_kill(pmp_kill),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src), .rsp_kill(rsp_kill)
`ifdef HAZARD3_PMP_ARB_FAULT_CAPTURE_EN
    , .fault_clr(fault_clr), .fault_sticky(fault_sticky), .fault_addr(fault_addr),
    .fault_src(fault_src)
`endif
  );

  hazard3_pmp_arb #(.W_ADDR(32), .STARVE_LIMIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(z_i_ready), .i_req_addr(i_req_addr),
    .i_req_m_mode(i_req_m_mode), .i_req_32bit(i_req_32bit),
    .d_req_valid(d_req_valid), .d_req_ready(z_d_ready), .d_req_addr(d_req_addr),
    .d_req_m_mode(d_req_m_mode), .d_req_write(d_req_write),
    .cfg_wen(cfg_wen),
    .pmp_addr(z_pmp_addr), .pmp_m_mode(z_pmp_m), .pmp_type(z_pmp_type),
    .pmp_32bit(z_pmp_32), .pmp_kill(1'b0),
    .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready), .rsp_src(z_rsp_src), .rsp_kill(z_rsp_kill)
`ifdef HAZARD3_PMP_ARB_FAULT_CAPTURE_EN
    , .fault_clr(1'b0), .fault_sticky(z_fault_sticky), .fault_addr(z_fault_addr),
    .fault_src(z_fault_src)
`endif
  );

  typedef struct {
    logic        src;
    logic [31:0] addr;
    logic [1:0]  typ;
    logic        m_mode;
    logic        b32;
  } req_t;

  typedef struct {
    logic src;
    logic kill;
  } rsp_t;

  req_t lookup_q[$];
  rsp_t rsp_q[$];
  int   losses = 0;
  int   exp_grant = 0;
  bit   exp_adv = 0, exp_can = 0;
  int   compared = 0, mismatched = 0;
  int   model_consumed = 0, dut_consumed = 0;

  logic        last_i_ready, last_d_ready, last_z_i, last_z_d;
  logic        last_rsp_valid, last_rsp_src, last_rsp_kill;
  logic [31:0] last_pmp_addr;
  logic [1:0]  last_pmp_type;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] ia, input logic im,
                               input logic i32, input logic dv, input logic [31:0] da,
                               input logic dm, input logic dw, input logic cw, input logic rr);
    i_req_valid = iv; i_req_addr = ia; i_req_m_mode = im; i_req_32bit = i32;
    d_req_valid = dv; d_req_addr = da; d_req_m_mode = dm; d_req_write = dw;
    cfg_wen = cw; rsp_ready = rr;
  endtask

  // Which side the arbiter should grant this cycle, from the in-flight queues.
  task automatic decide();
    exp_adv = (lookup_q.size() != 0) && !cfg_wen && (rsp_q.size() == 0 || rsp_ready);
    exp_can = (lookup_q.size() == 0) || exp_adv;
    exp_grant = 0;
    if (exp_can) begin
      if (LIMIT != 0 && losses >= LIMIT && i_req_valid) exp_grant = 1;
      else if (d_req_valid) exp_grant = 2;
      else if (i_req_valid) exp_grant = 1;
    end
  endtask

  task automatic modelCheck();
    req_t h;
    checkOutput("i_req_ready", {31'd0, i_req_ready}, {31'd0, exp_grant == 1});
    checkOutput("d_req_ready", {31'd0, d_req_ready}, {31'd0, exp_grant == 2});
    checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, rsp_q.size() != 0});
    if (rsp_q.size() != 0) begin
      checkOutput("rsp_src", {31'd0, rsp_src}, {31'd0, rsp_q[0].src});
      checkOutput("rsp_kill", {31'd0, rsp_kill}, {31'd0, rsp_q[0].kill});
    end
    if (lookup_q.size() != 0) begin
      h = lookup_q[0];
      checkOutput("pmp_addr", pmp_addr, h.addr);
      checkOutput("pmp_type", {30'd0, pmp_type}, {30'd0, h.typ});
      checkOutput("pmp_m_mode", {31'd0, pmp_m_mode}, {31'd0, h.m_mode});
      checkOutput("pmp_32bit", {31'd0, pmp_32bit}, {31'd0, h.b32});
    end else begin
      checkOutput("pmp_idle", {pmp_addr[28:0], pmp_type, pmp_m_mode | pmp_32bit}, 32'd0);
    end
`ifdef HAZARD3_PMP_ARB_FAULT_CAPTURE_EN
    checkOutput("fault_sticky", {31'd0, fault_sticky}, {31'd0, m_sticky});
    checkOutput("fault_addr", fault_addr, m_faddr);
    checkOutput("fault_src", {31'd0, fault_src}, {31'd0, m_fsrc});
`endif
  endtask

  task automatic updateModel();
    req_t h;
    rsp_t r;
    if (exp_adv) begin
      h = lookup_q.pop_front();
      r.src = h.src;
      r.kill = kill_fn(h.addr, h.typ, cfg_gen);
      if (rsp_q.size() != 0) begin
        void'(rsp_q.pop_front());
        model_consumed++;
      end
      rsp_q.push_back(r);
`ifdef HAZARD3_PMP_ARB_FAULT_CAPTURE_EN
      if (!fault_clr && r.kill && !m_sticky) begin
        m_sticky = 1'b1; m_faddr = h.addr; m_fsrc = h.src;
      end
`endif
    end else if (rsp_ready && rsp_q.size() != 0) begin
      void'(rsp_q.pop_front());
      model_consumed++;
    end
`ifdef HAZARD3_PMP_ARB_FAULT_CAPTURE_EN
    if (fault_clr) m_sticky = 1'b0;
`endif
    if (exp_grant == 2) begin
      h.src = RSP_SRC_D; h.addr = d_req_addr; h.typ = d_req_write ? PMP_TYPE_W : PMP_TYPE_R;
      h.m_mode = d_req_m_mode; h.b32 = 1'b0;
      lookup_q.push_back(h);
    end else if (exp_grant == 1) begin
      h.src = RSP_SRC_I; h.addr = i_req_addr; h.typ = PMP_TYPE_X;
      h.m_mode = i_req_m_mode; h.b32 = i_req_32bit;
      lookup_q.push_back(h);
    end
    if (!i_req_valid || exp_grant == 1) losses = 0;
    else if (exp_can && losses < LIMIT) losses++;
    if (cfg_wen) cfg_gen++;
  endtask

  task automatic resetModel();
    lookup_q.delete();
    rsp_q.delete();
    losses = 0;
`ifdef HAZARD3_PMP_ARB_FAULT_CAPTURE_EN
    m_sticky = 1'b0; m_faddr = '0; m_fsrc = 1'b0;
`endif
  endtask

  // One clock: check at the falling edge, advance the model just after the rising edge.
  task automatic step();
    @(negedge clk);
    decide();
    modelCheck();
    last_i_ready = i_req_ready; last_d_ready = d_req_ready;
    last_z_i = z_i_ready; last_z_d = z_d_ready;
    last_rsp_valid = rsp_valid; last_rsp_src = rsp_src; last_rsp_kill = rsp_kill;
    last_pmp_addr = pmp_addr; last_pmp_type = pmp_type;
    if (rsp_valid && rsp_ready) dut_consumed++;
    @(posedge clk);
    #1;
    updateModel();
  endtask

  task automatic drain(input int n);
    applyStimulus(0, '0, 0, 0, 0, '0, 0, 0, 0, 1);
    for (int k = 0; k < n; k++) step();
  endtask

  int base;

  initial begin
    $display("[TB] start");
    #2;
    checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("reset_pmp_addr", pmp_addr, 32'd0);
    checkOutput("reset_readies", {30'd0, i_req_ready, d_req_ready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single load at 0x2000.
    applyStimulus(0, '0, 0, 0, 1, 32'h2000, 0, 0, 0, 1);
    step();
    checkOutput("single_d_ready", {31'd0, last_d_ready}, 32'd1);
    applyStimulus(0, '0, 0, 0, 0, '0, 0, 0, 0, 1);
    step();
    checkOutput("single_pmp_type", {30'd0, last_pmp_type}, 32'd0);
    checkOutput("single_pmp_addr", last_pmp_addr, 32'h2000);
    step();
    checkOutput("single_rsp", {29'd0, last_rsp_valid, last_rsp_src, last_rsp_kill}, 32'b110);

    // Starvation override with both sides continuously requesting.
    drain(3);
    applyStimulus(1, 32'h300, 1, 1, 1, 32'h500, 0, 0, 0, 1);
    for (int k = 0; k < 10; k++) begin
      step();
      checkOutput("starve_i_grant", {31'd0, last_i_ready}, {31'd0, (k % 5) == 4});
      checkOutput("nostarve_i", {31'd0, last_z_i}, 32'd0);
      checkOutput("nostarve_d", {31'd0, last_z_d}, 32'd1);
    end

    // Response backpressure with both stages full.
    drain(3);
    base = dut_consumed;
    applyStimulus(0, '0, 0, 0, 1, 32'h600, 0, 1, 0, 0);
    step();
    applyStimulus(1, 32'h700, 0, 1, 0, '0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 32'h700, 0, 1, 1, 32'h800, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("bp_readies", {30'd0, last_i_ready, last_d_ready}, 32'd0);
      checkOutput("bp_rsp_hold", {30'd0, last_rsp_valid, last_rsp_src}, 32'b11);
    end
    applyStimulus(0, '0, 0, 0, 1, 32'h800, 1, 0, 0, 1);
    step();
    drain(5);
    checkOutput("bp_no_loss", dut_consumed - base, 32'd3);

    // Config fence re-query on a held fetch at 0x100.
    cfg_gen = '0;
    applyStimulus(1, 32'h100, 0, 1, 0, '0, 0, 0, 0, 1);
    step();
    checkOutput("fence_i_grant", {31'd0, last_i_ready}, 32'd1);
    applyStimulus(0, '0, 0, 0, 0, '0, 0, 0, 1, 1);
    step();
    applyStimulus(0, '0, 0, 0, 0, '0, 0, 0, 0, 1);
    step();
    checkOutput("fence_delay", {31'd0, last_rsp_valid}, 32'd0);
    step();
    checkOutput("fence_rsp", {29'd0, last_rsp_valid, last_rsp_src, last_rsp_kill}, 32'b101);
    drain(2);

    // Reset while both stages hold requests.
    applyStimulus(0, '0, 0, 0, 1, 32'h600, 0, 1, 0, 0);
    step();
    applyStimulus(1, 32'h700, 0, 1, 0, '0, 0, 0, 0, 0);
    step();
    applyStimulus(0, '0, 0, 0, 0, '0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("midrst_pmp_addr", pmp_addr, 32'd0);
    resetModel();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drain(1);
      checkOutput("postrst_no_rsp", {31'd0, last_rsp_valid}, 32'd0);
    end

`ifdef HAZARD3_PMP_ARB_FAULT_CAPTURE_EN
    // Fault capture: first killed store wins until cleared.
    cfg_gen = 32'd1;
    applyStimulus(0, '0, 0, 0, 1, 32'h40, 0, 1, 0, 1);
    step();
    applyStimulus(0, '0, 0, 0, 1, 32'h80, 0, 1, 0, 1);
    step();
    drain(4);
    checkOutput("fault_first", fault_addr, 32'h40);
    checkOutput("fault_set", {30'd0, fault_sticky, fault_src}, 32'b11);
    fault_clr = 1'b1;
    drain(1);
    fault_clr = 1'b0;
    checkOutput("fault_cleared", {31'd0, fault_sticky}, 32'd0);
    applyStimulus(0, '0, 0, 0, 1, 32'h2040, 0, 1, 0, 1);
    step();
    drain(4);
    checkOutput("fault_recapture", fault_addr, 32'h2040);
    checkOutput("fault_reset_sticky", {31'd0, fault_sticky}, 32'd1);
`endif

    // Random traffic obeying the request hold rule.
    for (int c = 0; c < 600; c++) begin
      if (i_req_valid && exp_grant != 1) begin
        if ($urandom_range(0, 19) == 0) i_req_valid = 1'b0;
      end else begin
        i_req_valid = ($urandom_range(0, 99) < 60);
        i_req_addr = $urandom;
        i_req_m_mode = 1'($urandom_range(0, 1));
        i_req_32bit = 1'($urandom_range(0, 1));
      end
      if (d_req_valid && exp_grant != 2) begin
        if ($urandom_range(0, 19) == 0) d_req_valid = 1'b0;
      end else begin
        d_req_valid = ($urandom_range(0, 99) < 50);
        d_req_addr = $urandom;
        d_req_m_mode = 1'($urandom_range(0, 1));
        d_req_write = 1'($urandom_range(0, 1));
      end
      cfg_wen = ($urandom_range(0, 99) < 15);
      rsp_ready = ($urandom_range(0, 99) < 70);
      step();
    end
    drain(6);
    checkOutput("total_consumed", dut_consumed, model_consumed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
